pool_window_buffer: RTL and testbench

- Streaming stage directly upstream of max_pooling.
- Accepts a row-major feature map one WIDTH-bit activation per transfer, buffers N-1 rows, and emits each non-overlapping NxN window (stride N) as a packed POOLING_NxN*POOLING_NxN*WIDTH word.
- That word is exactly the packed activation bus max_pooling consumes; for N=2, WIDTH=8 it is 32 bits.
- Valid/ready on both sides so it tolerates stalls from downstream.

---
 rtl/pool_window_buffer_pkg.sv | 17 +
 rtl/pool_line_mem.sv | 27 ++
 rtl/pool_window_buffer.sv | 149 ++++++++++++++
 tb/tb_pool_window_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pool_window_buffer_pkg.sv
// Shared defaults and window packing helpers for the pooling datapath.
// Element (rr,cc) of an NxN window sits at bit offset elem_off(rr,cc,N,W).
package pool_window_buffer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 2;

  function automatic int win_w(input int n, input int width);
    return n * n * width;
  endfunction

  function automatic int elem_off(input int rr, input int cc,
                                  input int n, input int width);
    return (rr * n + cc) * width;
  endfunction

endpackage

// File: rtl/pool_line_mem.sv
// Line memory for the N-1 upper window rows.
// Single write port, every entry readable combinationally.
module pool_line_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [DEPTH*WIDTH-1:0] rd_all
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rd_all = '0;
    for (int i = 0; i < DEPTH; i++)
      rd_all[i*WIDTH +: WIDTH] = mem_q[i];
  end

endmodule

// File: rtl/pool_window_buffer.sv
// Buffers N-1 rows of a row-major stream and emits each
// non-overlapping NxN window as one packed word.
module pool_window_buffer
  import pool_window_buffer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int POOLING_NxN = DEF_N,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [WIDTH-1:0]                         in_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [POOLING_NxN*POOLING_NxN*WIDTH-1:0] out_window,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_last
);

  localparam int N     = POOLING_NxN;
  localparam int WIN   = win_w(N, WIDTH);
  localparam int DEPTH = (N - 1) * IMG_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NW    = $clog2(N);

  if (N < 2 || N > 4 || (IMG_W % N) != 0 || (IMG_H % N) != 0)
  begin : g_bad_params
    $error("pool_window_buffer: illegal N/IMG_W/IMG_H");
  end

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [NW-1:0]    cm_q, cm_d;
  logic [NW-1:0]    rm_q, rm_d;
  logic [WIDTH-1:0] sr_q [N-1];
  logic [WIDTH-1:0] sr_d [N-1];
  logic [WIN-1:0]   win_q, win_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic                   in_xfer;
  logic                   col_end, row_end;
  logic                   last_row, last_col;
  logic                   complete;
  logic                   mem_we;
  logic [AW-1:0]          mem_waddr;
  logic [DEPTH*WIDTH-1:0] mem_rd;
  int                     cb;

  pool_line_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (in_data),
    .rd_all (mem_rd)
  );

  always_comb begin
    in_ready  = !valid_q || out_ready;
    in_xfer   = in_valid && in_ready;
    col_end   = col_q == CW'(IMG_W - 1);
    row_end   = row_q == RW'(IMG_H - 1);
    last_row  = rm_q == NW'(N - 1);
    last_col  = cm_q == NW'(N - 1);
    complete  = in_xfer && last_row && last_col;
    mem_we    = in_xfer && !last_row;
    mem_waddr = AW'(int'(rm_q) * IMG_W + int'(col_q));
    cb        = last_col ? int'(col_q) - (N - 1) : 0;

    col_d   = col_q;
    row_d   = row_q;
    cm_d    = cm_q;
    rm_d    = rm_q;
    sr_d    = sr_q;
    win_d   = win_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (in_xfer) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      cm_d  = last_col ? '0 : cm_q + 1'b1;
      if (col_end) begin
        row_d = row_end ? '0 : row_q + 1'b1;
        rm_d  = last_row ? '0 : rm_q + 1'b1;
      end
    end

    // Oldest captured pixel drifts to index 0 as the row advances.
    if (in_xfer && last_row && !last_col) begin
      for (int i = 0; i < N - 2; i++)
        sr_d[i] = sr_q[i+1];
      sr_d[N-2] = in_data;
    end

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (complete) begin
      valid_d = 1'b1;
      last_d  = row_end && col_end;
      for (int rr = 0; rr < N - 1; rr++)
        for (int cc = 0; cc < N; cc++)
          win_d[elem_off(rr, cc, N, WIDTH) +: WIDTH] =
            mem_rd[(rr * IMG_W + cb + cc) * WIDTH +: WIDTH];
      for (int cc = 0; cc < N - 1; cc++)
        win_d[elem_off(N - 1, cc, N, WIDTH) +: WIDTH] = sr_q[cc];
      win_d[elem_off(N - 1, N - 1, N, WIDTH) +: WIDTH] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      cm_q    <= '0;
      rm_q    <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      cm_q    <= cm_d;
      rm_q    <= rm_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign out_window = win_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Scoreboard bench for pool_window_buffer, N=2, 4x4 frames.
// Stimulus pushes expected windows; a negedge monitor pops and compares.
module tb_pool_window_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_window;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  typedef logic [7:0]  px_t  [16];
  typedef logic [31:0] win_t [4];
  typedef struct {
    logic [31:0] w;
    logic        l;
    bit          lat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mism     = 0;
  int   cyc      = 0;

  pool_window_buffer #(
    .WIDTH       (8),
    .POOLING_NxN (2),
    .IMG_W       (4),
    .IMG_H       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_window (out_window),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mism++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        compared++;
        mism++;
        $display("FAIL unexpected_window: got %h expected none",
                 out_window);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("window", out_window, e.w);
        chk("last", {31'b0, out_last}, {31'b0, e.l});
        if (e.lat) chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push(input logic [31:0] w, input logic l,
                      input bit lat);
    exp_t e;
    e.w   = w;
    e.l   = l;
    e.lat = lat;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] px);
    int n;
    n        = 0;
    in_data  = px;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      compared++;
      mism++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input px_t px, input win_t wins,
                           input bit gap, input bit lat,
                           input bit hold);
    int k;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      send(px[i]);
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        push(wins[k], i == 15, lat);
        k++;
      end
      if (hold && i == 5) begin
        out_ready = 1'b0;
        in_data   = px[6];
        in_valid  = 1'b1;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          chk("hold_window", out_window, wins[0]);
          chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  px_t  fa, fb, fs;
  win_t wa, wb, ws;
  logic [7:0] pat [4];

  initial begin
    pat[0] = 8'h80; pat[1] = 8'hFF; pat[2] = 8'h7F; pat[3] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      fa[i] = 8'(i);
      fb[i] = 8'(i + 16);
      fs[i] = pat[i % 4];
    end
    wa[0] = 32'h05040100; wa[1] = 32'h07060302;
    wa[2] = 32'h0D0C0908; wa[3] = 32'h0F0E0B0A;
    wb[0] = 32'h15141110; wb[1] = 32'h17161312;
    wb[2] = 32'h1D1C1918; wb[3] = 32'h1F1E1B1A;
    ws[0] = 32'hFF80FF80; ws[1] = 32'h017F017F;
    ws[2] = 32'hFF80FF80; ws[3] = 32'h017F017F;

    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_last", {31'b0, out_last}, 32'd0);
    chk("reset_out_window", out_window, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    run_frame(fa, wa, 1'b0, 1'b1, 1'b0);
    run_frame(fa, wa, 1'b1, 1'b0, 1'b0);
    run_frame(fa, wa, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      send(fa[i]);
      if (i == 5) push(wa[0], 1'b0, 1'b0);
      if (i == 7) push(wa[1], 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    run_frame(fb, wb, 1'b0, 1'b0, 1'b0);

    run_frame(fa, wa, 1'b0, 1'b0, 1'b0);
    run_frame(fb, wb, 1'b0, 1'b0, 1'b0);

    run_frame(fs, ws, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
